// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared definitions for the program-counter unit.
//   - next-PC select encodings (3 bits)
//   - default reset and instruction-memory window constants
//   - helpers for the branch offset extension and the fetch-window check
package pc_unit_pkg;

    localparam int unsigned NPC_OP_W = 3;

    typedef enum logic [2:0] {
        NPC_OP_PC4    = 3'd0,
        NPC_OP_BRANCH = 3'd1,
        NPC_OP_J      = 3'd2,
        NPC_OP_JR     = 3'd3
    } npc_op_e;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEF = 4096;

    // Sign-extend the 16-bit branch field and scale it to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
        return {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

    // A fetch address is usable only if word aligned and inside [base, last].
    function automatic logic fetch_legal(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] last);
        return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= last);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/target inputs and PC outputs of the program-counter unit.
//   master : controller side (drives en/npcOp/cmpTrue/imm16/imm26/rsData)
//   slave  : pc_unit side (drives pc/pc4/npc/pcErr)
interface pc_unit_if;
    import pc_unit_pkg::*;

    logic                en;
    logic [NPC_OP_W-1:0] npcOp;
    logic                cmpTrue;
    logic [15:0]         imm16;
    logic [25:0]         imm26;
    logic [31:0]         rsData;
    logic [31:0]         pc;
    logic [31:0]         pc4;
    logic [31:0]         npc;
    logic                pcErr;

    modport master (
        output en, npcOp, cmpTrue, imm16, imm26, rsData,
        input  pc, pc4, npc, pcErr
    );

    modport slave (
        input  en, npcOp, cmpTrue, imm16, imm26, rsData,
        output pc, pc4, npc, pcErr
    );

endinterface

// File: rtl/pc_unit_npc_calc.sv
// npc_calc: purely combinational next-PC generator.
//   in : pc, npcOp, cmpTrue, imm16, imm26, rsData
//   out: npc (selected next PC), pc4 (pc + 4, wraps)
module npc_calc
    import pc_unit_pkg::*;
(
    input  logic [31:0]         pc,
    input  logic [NPC_OP_W-1:0] npcOp,
    input  logic                cmpTrue,
    input  logic [15:0]         imm16,
    input  logic [25:0]         imm26,
    input  logic [31:0]         rsData,
    output logic [31:0]         npc,
    output logic [31:0]         pc4
);

    npc_op_e op_s;

    assign op_s = npc_op_e'(npcOp);
    assign pc4  = pc + 32'd4;

    // Next-PC mux; unknown encodings fall through to sequential fetch.
    always_comb begin
        npc = pc4;
        case (op_s)
            NPC_OP_PC4: begin
                npc = pc4;
            end
            NPC_OP_BRANCH: begin
                if (cmpTrue) begin
                    npc = pc4 + branch_offset(imm16);
                end else begin
                    npc = pc4;
                end
            end
            NPC_OP_J: begin
                // Region bits come from the current pc, not pc4.
                npc = {pc[31:28], imm26, 2'b00};
            end
            NPC_OP_JR: begin
                npc = rsData;
            end
            default: begin
                npc = pc4;
            end
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter register with fetch-window fault detection.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset (pc <= PC_RESET, pcErr <= 0)
//   bus   : pc_unit_if.slave - controls in, pc/pc4/npc/pcErr out
// Once pcErr is set the pc freezes until reset; a stalled (en=0) cycle
// neither updates the pc nor checks the target.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
    parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
    input  logic     clk,
    input  logic     reset,
    pc_unit_if.slave bus
);

    localparam logic [31:0] IM_LAST = IM_BASE + (IM_WORDS << 2) - 32'd4;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pc_err_q;
    logic        pc_err_d;
    logic [31:0] npc_s;
    logic [31:0] pc4_s;
    logic        npc_legal_s;

    npc_calc u_npc_calc (
        .pc      (pc_q),
        .npcOp   (bus.npcOp),
        .cmpTrue (bus.cmpTrue),
        .imm16   (bus.imm16),
        .imm26   (bus.imm26),
        .rsData  (bus.rsData),
        .npc     (npc_s),
        .pc4     (pc4_s)
    );

    assign npc_legal_s = fetch_legal(npc_s, IM_BASE, IM_LAST);

    // Next-state for pc and the sticky fault flag.
    always_comb begin
        pc_d     = pc_q;
        pc_err_d = pc_err_q;
        if (pc_err_q) begin
            pc_d     = pc_q;
            pc_err_d = 1'b1;
        end else if (bus.en) begin
            if (npc_legal_s) begin
                pc_d = npc_s;
            end else begin
                pc_err_d = 1'b1;
            end
        end else begin
            pc_d     = pc_q;
            pc_err_d = pc_err_q;
        end
    end

    // State registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= PC_RESET;
            pc_err_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            pc_err_q <= pc_err_d;
        end
    end

    assign bus.pc    = pc_q;
    assign bus.pcErr = pc_err_q;
    assign bus.pc4   = pc4_s;
    assign bus.npc   = npc_s;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed + randomized check of pc_unit against a reference
// model that computes next-PC values with plain integer arithmetic.
module tb_pc_unit;

    localparam longint BASE  = 64'h3000;
    localparam longint LAST  = 64'h3000 + 4 * 4096 - 4;

    logic clk;
    logic reset;
    int   cmp_cnt;
    int   fail_cnt;
    logic [31:0] m_pc;
    logic        m_err;

    pc_unit_if bus ();

    pc_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference next PC from the instruction-set rules.
    function automatic logic [31:0] ref_npc(input logic [31:0] p, input logic [2:0] op,
                                            input logic c, input logic [15:0] i16,
                                            input logic [25:0] i26, input logic [31:0] rs);
        longint seq;
        longint off;
        int     soff;
        seq  = longint'(p) + 4;
        soff = $signed(i16);
        off  = longint'(soff) * 4;
        case (op)
            3'd1:    return c ? 32'(seq + off) : 32'(seq);
            3'd2:    return 32'((longint'(p) / 268435456) * 268435456 + longint'(i26) * 4);
            3'd3:    return rs;
            default: return 32'(seq);
        endcase
    endfunction

    function automatic logic ref_legal(input logic [31:0] a);
        longint n;
        n = longint'(a);
        return (n % 4 == 0) && (n >= BASE) && (n <= LAST);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic e, input logic [2:0] op, input logic c,
                         input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs);
        bus.en      = e;
        bus.npcOp   = op;
        bus.cmpTrue = c;
        bus.imm16   = i16;
        bus.imm26   = i26;
        bus.rsData  = rs;
        #1;
    endtask

    task automatic check_comb(input string tag);
        check({tag, ".npc"}, bus.npc,
              ref_npc(m_pc, bus.npcOp, bus.cmpTrue, bus.imm16, bus.imm26, bus.rsData));
        check({tag, ".pc4"}, bus.pc4, m_pc + 32'd4);
    endtask

    // Advance the model by one edge, then compare the registered outputs.
    task automatic tick(input string tag);
        logic [31:0] n;
        n = ref_npc(m_pc, bus.npcOp, bus.cmpTrue, bus.imm16, bus.imm26, bus.rsData);
        if (reset) begin
            m_pc  = 32'h3000;
            m_err = 1'b0;
        end else if (!m_err && bus.en) begin
            if (ref_legal(n)) m_pc = n;
            else m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, ".pc"}, bus.pc, m_pc);
        check({tag, ".pcErr"}, {31'd0, bus.pcErr}, {31'd0, m_err});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick("rst");
        reset = 1'b0;
    endtask

    initial begin
        cmp_cnt  = 0;
        fail_cnt = 0;
        m_pc     = 32'h0;
        m_err    = 1'b0;
        reset    = 1'b1;
        drive(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);

        // Reset for two cycles, then sequential fetch.
        tick("reset0");
        tick("reset1");
        check("reset.pc_const", bus.pc, 32'h0000_3000);
        reset = 1'b0;
        tick("seq0");
        check("seq0.const", bus.pc, 32'h0000_3004);
        tick("seq1");
        tick("seq2");
        check("seq2.const", bus.pc, 32'h0000_300C);
        tick("seq3");

        // Backward taken branch from 0x3010.
        drive(1'b1, 3'd1, 1'b1, 16'hFFFC, 26'h0, 32'h0);
        check_comb("br_taken");
        check("br_taken.npc_const", bus.npc, 32'h0000_3004);
        tick("br_taken");

        // Return to 0x3010, then the same branch not taken.
        drive(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3010);
        tick("jr3010");
        drive(1'b1, 3'd1, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        check_comb("br_not");
        tick("br_not");
        check("br_not.const", bus.pc, 32'h0000_3014);

        // Jump from 0x3000.
        do_reset();
        drive(1'b1, 3'd2, 1'b0, 16'h0, 26'h000_0C10, 32'h0);
        check_comb("jump");
        check("jump.npc_const", bus.npc, 32'h0000_3040);
        tick("jump");

        // Misaligned jr faults; later ops are ignored; reset clears.
        do_reset();
        drive(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3002);
        tick("jr_misalign");
        check("jr_misalign.err_const", {31'd0, bus.pcErr}, 32'd1);
        drive(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        check_comb("frozen");
        tick("frozen0");
        drive(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_3100);
        tick("frozen1");
        do_reset();

        // Upper window edge.
        drive(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_7000);
        tick("jr_7000");
        do_reset();
        drive(1'b1, 3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_6FFC);
        tick("jr_6ffc");
        check("jr_6ffc.const", bus.pc, 32'h0000_6FFC);
        drive(1'b1, 3'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        tick("step_7000");
        check("step_7000.err_const", {31'd0, bus.pcErr}, 32'd1);

        // Stall with a taken branch presented, then release.
        do_reset();
        drive(1'b0, 3'd1, 1'b1, 16'h0004, 26'h0, 32'h0);
        for (int i = 0; i < 4; i++) tick("stall");
        bus.en = 1'b1;
        #1;
        tick("release");
        check("release.const", bus.pc, 32'h0000_3014);

        // Most negative branch offset leaves the window.
        do_reset();
        drive(1'b1, 3'd1, 1'b1, 16'h8000, 26'h0, 32'h0);
        check_comb("br_8000");
        check("br_8000.npc_const", bus.npc, 32'hFFFE_3004);
        tick("br_8000");

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            logic [25:0] i26;
            logic [15:0] i16;
            if ($urandom_range(0, 3) == 0) rs = $urandom();
            else rs = 32'h3000 + (32'($urandom_range(0, 4095)) << 2) + 32'($urandom_range(0, 1) * $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) i26 = 26'($urandom());
            else i26 = 26'(32'h0C00 + 32'($urandom_range(0, 4095)));
            if ($urandom_range(0, 7) == 0) i16 = 16'($urandom());
            else i16 = 16'($signed(32'($urandom_range(0, 64)) - 32'd32));
            drive($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), 1'($urandom()), i16, i26, rs);
            reset = ($urandom_range(0, 39) == 0);
            check_comb("rnd");
            tick("rnd");
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
